load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
//   - Access-size codes carried on req_size.
//   - FSM state codes used by load_store_unit.
//   - is_misaligned(): decides whether a request must bypass memory and
//     respond with an error.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_ACCESS      = 2'd1;
  localparam logic [1:0] ST_MERGE_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP        = 2'd3;

  // Size code 2'b11 is illegal and is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit (little-endian lanes).
// Ports:
//   word        : word read from memory
//   size        : access size code (lsu_pkg SZ_*)
//   addr_lo     : byte offset within the word
//   is_unsigned : 1 = zero-extend loads, 0 = sign-extend
//   wdata       : right-aligned store data
//   load_data   : addressed lane, extended to DATA_WIDTH
//   merged_word : word with only the addressed lane replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged_word
);

  logic [4:0]            byte_sh;
  logic [4:0]            half_sh;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] lane_ins;

  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[1], 4'b0000};

  always_comb begin
    lane_b = 8'(word >> byte_sh);
    lane_h = 16'(word >> half_sh);
    case (size)
      SZ_BYTE: begin
        load_data = {{(DATA_WIDTH-8){~is_unsigned & lane_b[7]}}, lane_b};
        lane_mask = DATA_WIDTH'(8'hFF) << byte_sh;
        lane_ins  = DATA_WIDTH'(wdata[7:0]) << byte_sh;
      end
      SZ_HALF: begin
        load_data = {{(DATA_WIDTH-16){~is_unsigned & lane_h[15]}}, lane_h};
        lane_mask = DATA_WIDTH'(16'hFFFF) << half_sh;
        lane_ins  = DATA_WIDTH'(wdata[15:0]) << half_sh;
      end
      default: begin
        load_data = word;
        lane_mask = '1;
        lane_ins  = wdata;
      end
    endcase
    merged_word = (word & ~lane_mask) | lane_ins;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time from the
// pipeline, sequences it against a single-port word memory with a
// combinational read, and returns a one-cycle response.
// Ports:
//   clk, reset (async, active-low)
//   req_*      : request handshake and fields (req_ready high only in IDLE)
//   resp_*     : one-cycle response pulse, extended load data, error flag
//   mem_*      : word-indexed memory port (read and write never together)
// Sub-word stores are read-modify-write: read in ACCESS, write the merged
// word in MERGE_WRITE.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_error,
  output logic [MEMORY_DEPTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);

  logic [1:0]              state_q, state_d;
  logic                    error_q, error_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic [MEMORY_DEPTH+1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;

  logic                    accept;
  logic                    in_access;
  logic                    in_merge;
  logic                    word_store;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [DATA_WIDTH-1:0]   merged_word;

  // Upper address bits are deliberately dropped: addresses wrap modulo memory.
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEMORY_DEPTH+2];

  assign in_access  = (state_q == ST_ACCESS);
  assign in_merge   = (state_q == ST_MERGE_WRITE);
  assign word_store = write_q & (size_q == SZ_WORD);
  assign accept     = req_valid & (state_q == ST_IDLE);

  lsu_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .word        (mem_read_data),
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    write_d    = accept ? req_write                   : write_q;
    size_d     = accept ? req_size                    : size_q;
    unsigned_d = accept ? req_unsigned                : unsigned_q;
    addr_d     = accept ? req_addr[MEMORY_DEPTH+1:0]  : addr_q;
    wdata_d    = accept ? req_wdata                   : wdata_q;
    // word_q holds the extracted load result or, for a sub-word store,
    // the merged word to be written in MERGE_WRITE.
    word_d     = in_access ? (write_q ? merged_word : load_data) : word_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            error_d = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            error_d = 1'b0;
          end
        end
      end
      ST_ACCESS:      state_d = (write_q && !word_store) ? ST_MERGE_WRITE : ST_RESP;
      ST_MERGE_WRITE: state_d = ST_RESP;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q    <= write_d;
    size_q     <= size_d;
    unsigned_q <= unsigned_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    word_q     <= word_d;
  end

  // All memory/response outputs decode from state_q, so the asynchronous
  // reset of state_q drops mem_write immediately.
  assign req_ready      = reset & (state_q == ST_IDLE);
  assign resp_valid     = (state_q == ST_RESP);
  assign resp_error     = resp_valid & error_q;
  assign resp_rdata     = (resp_valid & ~error_q & ~write_q) ? word_q : '0;
  assign mem_write      = (in_access & word_store) | in_merge;
  assign mem_read       = in_access & ~word_store;
  assign mem_address    = (in_access | in_merge) ? addr_q[MEMORY_DEPTH+1:2] : '0;
  assign mem_write_data = mem_write ? (in_merge ? word_q : wdata_q) : '0;

endmodule
